// File: rtl/spi_slave_fsm.sv
// SPI-slave transaction sequencer: counts conditioned SCLK edge pulses and emits the
// address-latch, shift-load, memory-write and MISO-enable controls for one cmd+data frame.
module spi_slave_fsm #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_BITS = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic sclk_rise,
  input  logic sclk_fall,
  input  logic rw_bit,
  output logic sr_load,
  output logic addr_we,
  output logic dm_we,
  output logic miso_en,
  output logic busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  // Command byte is ADDR_BITS address bits plus the R/W bit.
  localparam logic [CntW-1:0] CmdLast  = CntW'(ADDR_BITS);
  localparam logic [CntW-1:0] DataLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StLatch,
    StReadLoad,
    StReadSend,
    StWriteGet,
    StWriteStore,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (!cs_n) state_d = StGetAddr;
      end
      StGetAddr: begin
        if (sclk_rise) begin
          if (cnt_q == CmdLast) state_d = StLatch;
          else                  cnt_d   = cnt_q + CntW'(1);
        end
      end
      StLatch: begin
        state_d = rw_bit ? StReadLoad : StWriteGet;
      end
      StReadLoad: begin
        state_d = StReadSend;
      end
      StReadSend: begin
        if (sclk_fall) begin
          if (cnt_q == DataLast) state_d = StDone;
          else                   cnt_d   = cnt_q + CntW'(1);
        end
      end
      StWriteGet: begin
        if (sclk_rise) begin
          if (cnt_q == DataLast) state_d = StWriteStore;
          else                   cnt_d   = cnt_q + CntW'(1);
        end
      end
      StWriteStore: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Deselect overrides everything, so a pending strobe state is abandoned.
    if (cs_n && (state_q != StIdle)) state_d = StIdle;
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign addr_we = (state_q == StLatch);
  assign sr_load = (state_q == StReadLoad);
  assign dm_we   = (state_q == StWriteStore);
  assign miso_en = (state_q == StReadSend);
  assign busy    = (state_q != StIdle);

endmodule
